xor_bist: RTL and testbench

Built-in self-test engine for the two-input XOR gate cell (`gate_xor`). It drives the gate's `inp1`/`inp2` through the full truth table in Gray order, holding each vector for a programmable number of cycles. At the end of each hold window it samples the gate's `out`, compares it against the expected XOR, and counts mismatches. The block is the synthesizable replacement for bench-side stimulus and monitoring, and sits beside the gate instance in self-checking builds.

---
 rtl/xor_bist.sv | 120 ++++++++++++
 tb/tb_xor_bist.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_bist.sv
// rtl/xor_bist.sv - BIST sequencer that sweeps a 2-input XOR cell in Gray order and counts mismatches
// Each vector is held HOLD_CYCLES cycles, sampled on its last edge, and the run repeats PASSES times.
module xor_bist #(
  parameter int HOLD_CYCLES = 10,
  parameter int PASSES      = 1,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             tst_inp1,
  output logic             tst_inp2,
  input  logic             tst_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic [1:0]       vec_idx
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [HW-1:0]    hold_q;
  logic [PW-1:0]    pass_cnt_q;
  logic [1:0]       vec_q;
  logic             inp1_q, inp2_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       fail_q;

  logic             sample_edge, mismatch, last_sample;
  logic [1:0]       vec_d;
  logic [ERR_W-1:0] err_d;
  logic [3:0]       fail_d;

  always_comb begin
    sample_edge = (state_q == RUN) && (hold_q == HOLD_LAST);
    // The Gray order makes the expected XOR of vector k equal to k[0]
    mismatch    = sample_edge && (tst_out != vec_q[0]);
    last_sample = sample_edge && (vec_q == 2'd3) && (pass_cnt_q == PASS_LAST);
    vec_d       = vec_q + 2'd1;
    err_d       = err_q;
    fail_d      = fail_q;
    if (mismatch) begin
      if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
      fail_d[vec_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      pass_cnt_q <= '0;
      vec_q      <= '0;
      inp1_q     <= 1'b0;
      inp2_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_q     <= '0;
            hold_q     <= '0;
            vec_q      <= '0;
            pass_cnt_q <= '0;
            inp1_q     <= 1'b0;
            inp2_q     <= 1'b0;
          end
        end
        RUN: begin
          if (sample_edge) begin
            hold_q <= '0;
            err_q  <= err_d;
            fail_q <= fail_d;
            vec_q  <= vec_d;
            if (last_sample) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
              inp1_q  <= 1'b0;
              inp2_q  <= 1'b0;
            end else begin
              inp1_q <= vec_d[1];
              inp2_q <= vec_d[1] ^ vec_d[0];
              if (vec_q == 2'd3) pass_cnt_q <= pass_cnt_q + PW'(1);
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tst_inp1  = inp1_q;
  assign tst_inp2  = inp2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign vec_idx   = vec_q;
endmodule

// File: tb/tb_xor_bist.sv
// tb/tb_xor_bist.sv - randomized self-checking bench for xor_bist against a window-arithmetic model
// Three parameterisations run side by side; a gate model with selectable faults closes the loop.
module tb_xor_bist;
  localparam int NI = 3;
  localparam int HC [NI] = '{10, 1, 4};
  localparam int PC [NI] = '{1, 3, 2};
  localparam int EC [NI] = '{8, 2, 8};

  typedef struct packed {
    logic       inp1;
    logic       inp2;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [3:0] fail;
    logic [1:0] vec;
  } obs_t;

  logic          clk = 1'b0;
  logic [NI-1:0] rst = '1;
  logic [NI-1:0] start = '0;
  logic [NI-1:0] inp1, inp2, gout, busy, done, pass_o;
  logic [NI-1:0] noise = '0;
  logic [7:0]    errc [NI];
  logic [3:0]    fvec [NI];
  logic [1:0]    vidx [NI];

  // Gate modes: 0 good, 1 stuck-0, 2 stuck-1, 3 XNOR, 4 good but noisy before the sample cycle
  int   mode_sel [NI] = '{0, 0, 0};
  int   gmode [NI] = '{0, 0, 0};
  int   e0 [NI] = '{0, 0, 0};
  logic run_v [NI] = '{1'b0, 1'b0, 1'b0};
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [EC[g]-1:0] ec;
    xor_bist #(.HOLD_CYCLES(HC[g]), .PASSES(PC[g]), .ERR_W(EC[g])) u_dut (
      .clk(clk), .rst(rst[g]), .start(start[g]),
      .tst_inp1(inp1[g]), .tst_inp2(inp2[g]), .tst_out(gout[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass_o[g]),
      .err_count(ec), .fail_vec(fvec[g]), .vec_idx(vidx[g])
    );
    assign errc[g] = 8'(ec);

    always_comb begin
      int   t;
      logic x;
      logic v;
      t = cyc - e0[g];
      x = inp1[g] ^ inp2[g];
      v = x;
      case (gmode[g])
        1: v = 1'b0;
        2: v = 1'b1;
        3: v = ~x;
        4: v = ((t % HC[g]) == HC[g] - 1) ? x : noise[g];
        default: v = x;
      endcase
      gout[g] = v;
    end
  end

  function automatic bit mism(input int mode, input int k);
    case (mode)
      1: return (k % 2) == 1;
      2: return (k % 2) == 0;
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_busy(input int i, input int c);
    return run_v[i] && ((c - e0[i]) < 4 * PC[i] * HC[i]);
  endfunction

  // Expected outputs during cycle c: derived from how many hold windows have completed since E0
  function automatic obs_t expect_obs(input int i, input int c);
    obs_t o;
    int   t, n, w, cnt, k, maxc;
    o = '0;
    if (!run_v[i]) return o;
    n    = 4 * PC[i] * HC[i];
    t    = c - e0[i];
    w    = (t < n) ? t / HC[i] : 4 * PC[i];
    maxc = (1 << EC[i]) - 1;
    cnt  = 0;
    for (int j = 0; j < w; j++) begin
      if (mism(gmode[i], j % 4)) begin
        cnt++;
        o.fail[j % 4] = 1'b1;
      end
    end
    o.err = 8'((cnt > maxc) ? maxc : cnt);
    if (t < n) begin
      k      = w % 4;
      o.busy = 1'b1;
      o.vec  = 2'(k);
      o.inp1 = k[1];
      o.inp2 = k[1] ^ k[0];
    end else begin
      o.done = 1'b1;
      o.pass = (cnt == 0);
    end
    return o;
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= NI'($urandom);
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        run_v[i] <= 1'b0;
      end else if (start[i] && !m_busy(i, cyc)) begin
        run_v[i] <= 1'b1;
        e0[i]    <= cyc + 1;
        gmode[i] <= mode_sel[i];
      end
    end
  end

  task automatic check(input string name, input int i, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", name, i, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        obs_t e;
        e = expect_obs(i, cyc);
        check("inp1", i, int'(inp1[i]), int'(e.inp1));
        check("inp2", i, int'(inp2[i]), int'(e.inp2));
        check("busy", i, int'(busy[i]), int'(e.busy));
        check("done", i, int'(done[i]), int'(e.done));
        check("pass", i, int'(pass_o[i]), int'(e.pass));
        check("err_count", i, int'(errc[i]), int'(e.err));
        check("fail_vec", i, int'(fvec[i]), int'(e.fail));
        check("vec_idx", i, int'(vidx[i]), int'(e.vec));
      end
    end
  end

  // Pulses start, optionally re-pulses or resets mid-run; returns run length or -1 if reset
  task automatic run(input int i, input int mode, input int repulse_at, input int abort_at,
                     output int cycles);
    int cnt;
    mode_sel[i] = mode;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    cnt = 0;
    while (!done[i] && cnt < 2000) begin
      if (cnt == repulse_at) start[i] = 1'b1;
      if (cnt == abort_at) rst[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      if (rst[i]) begin
        rst[i] = 1'b0;
        cycles = -1;
        return;
      end
      cnt++;
    end
    if (cnt >= 2000) check("done_timeout", i, cnt, 0);
    cycles = cnt;
  endtask

  task automatic pin(input int i, input int cyc_act, input int cyc_exp, input int p,
                     input int err, input int fv);
    check("run_len", i, cyc_act, cyc_exp);
    check("pin_pass", i, int'(pass_o[i]), p);
    check("pin_err", i, int'(errc[i]), err);
    check("pin_fail_vec", i, int'(fvec[i]), fv);
    check("pin_busy", i, int'(busy[i]), 0);
  endtask

  initial begin
    int c;
    rst = '1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst = '0;
    @(negedge clk);

    run(0, 0, -1, -1, c); pin(0, c, 40, 1, 0, 4'b0000);
    run(0, 1, -1, -1, c); pin(0, c, 40, 0, 2, 4'b1010);
    run(2, 3, -1, -1, c); pin(2, c, 32, 0, 8, 4'b1111);
    run(1, 2, -1, -1, c); pin(1, c, 12, 0, 3, 4'b0101);
    run(0, 4, -1, -1, c); pin(0, c, 40, 1, 0, 4'b0000);

    run(0, 0, -1, 15, c);
    check("abort_ret", 0, c, -1);
    check("abort_busy", 0, int'(busy[0]), 0);
    check("abort_vec", 0, int'(vidx[0]), 0);
    check("abort_inp", 0, int'({inp1[0], inp2[0]}), 0);
    run(0, 0, 5, -1, c); pin(0, c, 40, 1, 0, 4'b0000);

    run(1, 0, -1, -1, c); pin(1, c, 12, 1, 0, 4'b0000);
    run(1, 0, -1, -1, c); pin(1, c, 12, 1, 0, 4'b0000);

    rst[2] = 1'b1;
    start[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    start[2] = 1'b0;
    check("rst_beats_start", 2, int'(busy[2]), 0);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        start[i] = ($urandom_range(0, 7) == 0);
        rst[i] = ($urandom_range(0, 96) == 0);
        mode_sel[i] = $urandom_range(0, 4);
      end
      @(negedge clk);
    end
    start = '0;
    rst = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
